// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD power-up controller: ROM opcodes, FSM states,
// panel command bytes and common RGB565 colours.
package lcd_pkg;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } lcd_op_e;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    ROM_FETCH,
    ROM_WRITE,
    ROM_DELAY,
    FILL_HDR,
    FILL_PIX,
    DONE
  } lcd_state_e;

  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_RASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  localparam int HDR_WORDS = 11;

  function automatic logic [9:0] rom_entry(lcd_op_e op, logic [7:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Init-sequence ROM: combinational index -> {op, arg} lookup.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int ROM_DEPTH = 128,
  parameter int AW        = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic [AW-1:0] idx,
  output logic [9:0]    entry
);

  function automatic logic [9:0] init_word(int i);
    case (i)
      0:       return rom_entry(OP_CMD, CMD_SLPOUT);
      1:       return rom_entry(OP_DELAY, 8'd3);
      2:       return rom_entry(OP_DATA, 8'h55);
      default: return rom_entry(OP_END, 8'h00);
    endcase
  endfunction

  logic [9:0] rom [ROM_DEPTH];

  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    assign rom[gi] = init_word(gi);
  end

  assign entry = rom[idx];

endmodule

// File: rtl/lcd_init_ctrl.sv
// LCD power-up controller: panel reset timing, ROM-driven init script, then
// a full-screen clear with a sampled RGB565 colour.
module lcd_init_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_PER_MS  = 50000,
  parameter int RST_LOW_MS  = 100,
  parameter int RST_WAIT_MS = 50,
  parameter int H_RES       = 240,
  parameter int V_RES       = 320,
  parameter int ROM_DEPTH   = 128
) (
  input  logic        sys_clk_50MHz,
  input  logic        sys_rst,
  input  logic        wr_done,
  input  logic        reinit,
  input  logic [15:0] fill_color,
  output logic        lcd_rst,
  output logic [8:0]  init_data,
  output logic        en_write,
  output logic        init_done,
  output logic        busy
);

  localparam int PIX_WORDS = H_RES * V_RES * 2;
  localparam int PIX_W     = $clog2(PIX_WORDS + 1);
  localparam int IDX_W     = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int PRE_W     = $clog2(CLK_PER_MS + 1);
  localparam int MS_W      = 16;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROM_DEPTH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_WORDS - 1);
  localparam logic [3:0]       HDR_LAST = 4'(HDR_WORDS - 1);
  localparam logic [15:0]      H_LAST   = 16'(H_RES - 1);
  localparam logic [15:0]      V_LAST   = 16'(V_RES - 1);

  lcd_state_e       state_reg, state_next;
  logic [PRE_W-1:0] pre_reg;
  logic [MS_W-1:0]  ms_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [3:0]       hdr_reg;
  logic [PIX_W-1:0] pix_reg;
  logic [15:0]      color_reg;

  logic [9:0]       rom_word;
  lcd_op_e          rom_op;
  logic [7:0]       rom_arg;
  logic [MS_W-1:0]  ms_target;
  logic             ms_tick, timer_done, timed_state, rom_step;

  lcd_init_rom #(.ROM_DEPTH(ROM_DEPTH), .AW(IDX_W)) u_rom (
    .idx   (idx_reg),
    .entry (rom_word)
  );

  assign rom_op  = lcd_op_e'(rom_word[9:8]);
  assign rom_arg = rom_word[7:0];

  function automatic logic [8:0] hdr_word(logic [3:0] i);
    case (i)
      4'd0:    return {1'b0, CMD_CASET};
      4'd3:    return {1'b1, H_LAST[15:8]};
      4'd4:    return {1'b1, H_LAST[7:0]};
      4'd5:    return {1'b0, CMD_RASET};
      4'd8:    return {1'b1, V_LAST[15:8]};
      4'd9:    return {1'b1, V_LAST[7:0]};
      4'd10:   return {1'b0, CMD_RAMWR};
      default: return 9'h100;
    endcase
  endfunction

  // One prescaler/ms counter pair serves every timed state; it restarts on each state change.
  assign timed_state = (state_reg == RST_LOW) || (state_reg == RST_WAIT) || (state_reg == ROM_DELAY);
  assign ms_tick     = (pre_reg == PRE_LAST);

  always_comb begin
    ms_target = '0;
    case (state_reg)
      RST_LOW:   ms_target = MS_W'(RST_LOW_MS);
      RST_WAIT:  ms_target = MS_W'(RST_WAIT_MS);
      ROM_DELAY: ms_target = {8'h00, rom_arg};
      default:   ms_target = '0;
    endcase
  end

  // A zero-length wait still occupies its state for one cycle.
  assign timer_done = (ms_target == '0) || (ms_tick && (ms_reg == ms_target - 1'b1));
  assign rom_step   = ((state_reg == ROM_WRITE) && wr_done) || ((state_reg == ROM_DELAY) && timer_done);

  always_comb begin
    state_next = state_reg;
    en_write   = 1'b0;
    init_data  = 9'h000;
    case (state_reg)
      RST_LOW:   if (timer_done) state_next = RST_WAIT;
      RST_WAIT:  if (timer_done) state_next = ROM_FETCH;
      ROM_FETCH: begin
        case (rom_op)
          OP_CMD, OP_DATA: state_next = ROM_WRITE;
          OP_DELAY:        state_next = ROM_DELAY;
          default:         state_next = FILL_HDR;
        endcase
      end
      ROM_WRITE: begin
        en_write  = 1'b1;
        init_data = {rom_word[8], rom_arg};
        if (wr_done) state_next = (idx_reg == IDX_LAST) ? FILL_HDR : ROM_FETCH;
      end
      ROM_DELAY: if (timer_done) state_next = (idx_reg == IDX_LAST) ? FILL_HDR : ROM_FETCH;
      FILL_HDR: begin
        en_write  = 1'b1;
        init_data = hdr_word(hdr_reg);
        if (wr_done && (hdr_reg == HDR_LAST)) state_next = FILL_PIX;
      end
      FILL_PIX: begin
        en_write  = 1'b1;
        init_data = {1'b1, pix_reg[0] ? color_reg[7:0] : color_reg[15:8]};
        if (wr_done && (pix_reg == PIX_LAST)) state_next = DONE;
      end
      DONE:      if (reinit) state_next = RST_LOW;
      default:   state_next = RST_LOW;
    endcase
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_reg <= RST_LOW;
      pre_reg   <= '0;
      ms_reg    <= '0;
      idx_reg   <= '0;
      hdr_reg   <= '0;
      pix_reg   <= '0;
      color_reg <= '0;
    end else begin
      state_reg <= state_next;

      if ((state_next != state_reg) || !timed_state) begin
        pre_reg <= '0;
        ms_reg  <= '0;
      end else if (ms_tick) begin
        pre_reg <= '0;
        ms_reg  <= ms_reg + 1'b1;
      end else begin
        pre_reg <= pre_reg + 1'b1;
      end

      if ((state_reg == DONE) && reinit) begin
        idx_reg <= '0;
        hdr_reg <= '0;
        pix_reg <= '0;
      end else begin
        if (rom_step && (idx_reg != IDX_LAST)) idx_reg <= idx_reg + 1'b1;
        if ((state_reg == FILL_HDR) && wr_done)
          hdr_reg <= (hdr_reg == HDR_LAST) ? 4'd0 : hdr_reg + 1'b1;
        if ((state_reg == FILL_PIX) && wr_done)
          pix_reg <= (pix_reg == PIX_LAST) ? '0 : pix_reg + 1'b1;
      end

      if ((state_next == FILL_HDR) && (state_reg != FILL_HDR)) color_reg <= fill_color;
    end
  end

  assign lcd_rst   = (state_reg != RST_LOW);
  assign init_done = (state_reg == DONE);
  assign busy      = (state_reg != DONE);

endmodule
